// File: rtl/ram_pkg.sv
// Shared definitions for the RAM command initiator.
// Holds the command opcode encoding, the FSM state encoding and the
// default RAM geometry (8 words of 8 bits).
package ram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_SCAN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_CAPT = 3'd3,
        ST_SCAN    = 3'd4,
        ST_CLR     = 3'd5,
        ST_RESP    = 3'd6
    } state_e;

endpackage

// File: rtl/ram_master.sv
// Command-driven initiator for a synchronous single-port RAM with
// 1-cycle registered read latency (read-before-write).
//
// Commands (cmd_op): WRITE, READ, SCAN (sum all words), CLEAR (zero all
// words). One response per command on the rsp_* port.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready high only in IDLE
//   cmd_op/addr/wdata     command fields, latched on accept
//   rsp_valid/rsp_ready   response handshake; response held until taken
//   rsp_data              READ word / SCAN sum / 0 for WRITE and CLEAR
//   mem_addr/wdata/wr_en  to the RAM
//   mem_rdata             from the RAM, valid one cycle after mem_addr
//
// Every output is a flop; next values are computed from state_d so the
// registered outputs line up with the state they belong to.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a command, cmd_ready=1
// ST_WR      | single RAM write of the latched address/data
// ST_RD_ADDR | read address presented to the RAM
// ST_RD_CAPT | RAM data valid; load rsp_data (READ word or final SCAN sum)
// ST_SCAN    | walking addresses 0..DEPTH-1, accumulating returned words
// ST_CLR     | writing 0 to addresses 0..DEPTH-1
// ST_RESP    | rsp_valid=1 until rsp_ready
module ram_master
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W_DEF,
    localparam int SUM_W = DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [SUM_W-1:0]  rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [SUM_W-1:0]   acc_q, acc_d;

    logic               cmd_ready_d;
    logic               rsp_valid_d;
    logic [SUM_W-1:0]   rsp_data_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic               mem_wr_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_WRITE;
            idx_q     <= '0;
            acc_q     <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wr_en <= mem_wr_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        rsp_data_d  = rsp_data;
        // mem_addr only moves when a new address is issued, so it stays
        // quiet in IDLE and RESP.
        mem_addr_d  = mem_addr;
        mem_wdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = op_e'(cmd_op);
                    idx_d      = '0;
                    acc_d      = '0;
                    rsp_data_d = '0;
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
                            state_d     = ST_WR;
                            mem_addr_d  = cmd_addr;
                            mem_wdata_d = cmd_wdata;
                        end
                        OP_READ: begin
                            state_d    = ST_RD_ADDR;
                            mem_addr_d = cmd_addr;
                        end
                        OP_SCAN: begin
                            state_d    = ST_SCAN;
                            mem_addr_d = '0;
                        end
                        default: begin
                            state_d    = ST_CLR;
                            mem_addr_d = '0;
                        end
                    endcase
                end
            end

            ST_WR: begin
                state_d = ST_RESP;
            end

            ST_RD_ADDR: begin
                state_d = ST_RD_CAPT;
            end

            ST_RD_CAPT: begin
                // For SCAN this cycle carries the last word (address DEPTH-1).
                if (op_q == OP_SCAN) begin
                    rsp_data_d = acc_q + SUM_W'(mem_rdata);
                end else begin
                    rsp_data_d = SUM_W'(mem_rdata);
                end
                state_d = ST_RESP;
            end

            ST_SCAN: begin
                // Data returned now belongs to address idx_q-1; at idx_q==0
                // nothing has been read yet.
                if (idx_q != '0) begin
                    acc_d = acc_q + SUM_W'(mem_rdata);
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_RD_CAPT;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_addr_d = idx_q + 1'b1;
                end
            end

            ST_CLR: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_addr_d = idx_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        mem_wr_en_d = (state_d == ST_WR) || (state_d == ST_CLR);
    end

endmodule

// File: tb/tb_ram_master.sv
module tb_ram_master;
    import ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [10:0] rsp_data;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr_en;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rdata (mem_rdata)
    );

    // RAM: registered read, read-before-write.
    logic [7:0] ram [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: memory image, response value and the
    // cycle (counted from accept) at which each op's response is due.
    logic [7:0]  ref_mem [8] = '{default: 8'h00};
    logic        m_busy  = 1'b0;
    logic        m_ready = 1'b0;
    int          m_cyc   = 0;
    int          m_lat   = 0;
    logic [1:0]  m_op    = 2'b00;
    logic [2:0]  m_addr  = 3'd0;
    logic [7:0]  m_wdata = 8'h00;
    logic [10:0] m_rsp   = 11'h0;
    logic        chk_en  = 1'b0;
    int          wr_seen = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_cyc   = 0;
        end else if (m_busy) begin
            if (m_cyc >= m_lat && rsp_ready) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end else begin
                m_cyc++;
            end
        end else if (m_ready && cmd_valid) begin
            m_busy  = 1'b1;
            m_ready = 1'b0;
            m_cyc   = 1;
            m_op    = cmd_op;
            m_addr  = cmd_addr;
            m_wdata = cmd_wdata;
            case (cmd_op)
                OP_WRITE: begin m_lat = 2; m_rsp = 11'h0; ref_mem[cmd_addr] = cmd_wdata; end
                OP_READ:  begin m_lat = 3; m_rsp = {3'b000, ref_mem[cmd_addr]}; end
                OP_SCAN:  begin
                    m_lat = 10;
                    m_rsp = 11'h0;
                    for (int i = 0; i < 8; i++) m_rsp = m_rsp + {3'b000, ref_mem[i]};
                end
                default:  begin
                    m_lat = 9;
                    m_rsp = 11'h0;
                    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
                end
            endcase
        end else begin
            m_ready = 1'b1;
        end
    end

    // Per-cycle comparison of every DUT output against the reference.
    always @(negedge clk) begin
        logic       exp_rv;
        logic       exp_wr;
        logic [7:0] exp_wd;
        logic [2:0] exp_ad;
        logic       ad_chk;
        if (mem_wr_en === 1'b1) wr_seen++;
        if (chk_en) begin
            exp_rv = m_busy && (m_cyc >= m_lat);
            exp_wr = 1'b0;
            exp_wd = 8'h00;
            exp_ad = 3'd0;
            ad_chk = 1'b0;
            if (m_busy && m_cyc <= 8) begin
                case (m_op)
                    OP_WRITE: if (m_cyc == 1) begin exp_wr = 1'b1; exp_wd = m_wdata; exp_ad = m_addr; ad_chk = 1'b1; end
                    OP_READ:  if (m_cyc == 1) begin exp_ad = m_addr; ad_chk = 1'b1; end
                    OP_SCAN:  begin exp_ad = 3'(m_cyc - 1); ad_chk = 1'b1; end
                    default:  begin exp_wr = 1'b1; exp_ad = 3'(m_cyc - 1); ad_chk = 1'b1; end
                endcase
            end
            chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
            chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
            if (ad_chk) chk("mem_addr", 32'(mem_addr), 32'(exp_ad));
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] wd);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int hold, output logic [10:0] data, output int lat);
        logic [2:0] a_hold;
        lat = 0;
        data = 11'h7FF;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        data   = rsp_data;
        a_hold = mem_addr;
        if (hold > 0) begin
            // Offer a competing command; it must not be taken during RESP.
            cmd_valid = 1'b1;
            cmd_op    = OP_WRITE;
            cmd_addr  = 3'd1;
            cmd_wdata = 8'h77;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(data));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_mem_addr", 32'(mem_addr), 32'(a_hold));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [2:0] addr,
                       input logic [7:0] wd, input int hold, input logic [10:0] exp_data, input int exp_lat);
        logic [10:0] d;
        int          l;
        send(op, addr, wd);
        wait_rsp(hold, d, l);
        chk({name, "_data"}, 32'(d), 32'(exp_data));
        chk({name, "_lat"}, 32'(l), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_addr = 3'd0;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;

        // WRITE then READ back
        w0 = wr_seen;
        run("t1_write", OP_WRITE, 3'd3, 8'hA5, 0, 11'h000, 2);
        chk("t1_wr_cycles", 32'(wr_seen - w0), 32'd1);
        run("t2_read", OP_READ, 3'd3, 8'h00, 0, 11'h0A5, 3);

        // all-ones scan
        for (int i = 0; i < 8; i++) run("t3_fill", OP_WRITE, 3'(i), 8'hFF, 0, 11'h000, 2);
        run("t3_scan", OP_SCAN, 3'd0, 8'h00, 0, 11'h7F8, 10);

        // CLEAR then READ
        w0 = wr_seen;
        run("t4_clear", OP_CLEAR, 3'd0, 8'h00, 0, 11'h000, 9);
        chk("t4_wr_cycles", 32'(wr_seen - w0), 32'd8);
        run("t4_read", OP_READ, 3'd5, 8'h00, 0, 11'h000, 3);

        // mem[i] = 17*i+3, responses held off by rsp_ready
        for (int i = 0; i < 8; i++) run("t5_fill", OP_WRITE, 3'(i), 8'(17 * i + 3), 0, 11'h000, 2);
        run("t5_read_hold", OP_READ, 3'd4, 8'h00, 5, 11'h047, 3);
        run("t5_scan_hold", OP_SCAN, 3'd0, 8'h00, 3, 11'h1F4, 10);

        // reset during SCAN cycle 4
        send(OP_SCAN, 3'd0, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run("t6_write", OP_WRITE, 3'd2, 8'h3C, 0, 11'h000, 2);
        run("t6_read", OP_READ, 3'd2, 8'h00, 0, 11'h03C, 3);
        run("t6_scan", OP_SCAN, 3'd0, 8'h00, 0, 11'h20B, 10);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
